// File: rtl/eject_arbiter_if.sv
// Handshake bundle between the cw/ccw requesters, the ejection arbiter and the PE link.
interface eject_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  polarity;
    logic                  req_cw_even;
    logic                  req_cw_odd;
    logic                  req_ccw_even;
    logic                  req_ccw_odd;
    logic [DATA_WIDTH-1:0] data_cw_even;
    logic [DATA_WIDTH-1:0] data_cw_odd;
    logic [DATA_WIDTH-1:0] data_ccw_even;
    logic [DATA_WIDTH-1:0] data_ccw_odd;
    logic                  gnt_cw_even;
    logic                  gnt_cw_odd;
    logic                  gnt_ccw_even;
    logic                  gnt_ccw_odd;
    logic                  pero;
    logic                  peso;
    logic [DATA_WIDTH-1:0] pedo;

    modport master (
        output polarity, req_cw_even, req_cw_odd, req_ccw_even, req_ccw_odd,
        output data_cw_even, data_cw_odd, data_ccw_even, data_ccw_odd, pero,
        input  gnt_cw_even, gnt_cw_odd, gnt_ccw_even, gnt_ccw_odd, peso, pedo
    );

    modport slave (
        input  polarity, req_cw_even, req_cw_odd, req_ccw_even, req_ccw_odd,
        input  data_cw_even, data_cw_odd, data_ccw_even, data_ccw_odd, pero,
        output gnt_cw_even, gnt_cw_odd, gnt_ccw_even, gnt_ccw_odd, peso, pedo
    );
endinterface

// File: rtl/eject_arbiter.sv
// Ring-node ejection scheduler: per-VC single-slot buffer with cw/ccw round-robin,
// each slot draining to the PE only in the link cycle matching its VC polarity.
module eject_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input logic           clk,
    input logic           rst,
    eject_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // Index 0 = even VC, index 1 = odd VC
    state_t                r_state   [2];
    logic [DATA_WIDTH-1:0] r_slot    [2];
    logic                  r_prio    [2];
    logic                  r_gnt_cw  [2];
    logic                  r_gnt_ccw [2];
    logic                  r_peso;
    logic [DATA_WIDTH-1:0] r_pedo;

    logic                  w_req_cw   [2];
    logic                  w_req_ccw  [2];
    logic [DATA_WIDTH-1:0] w_data_cw  [2];
    logic [DATA_WIDTH-1:0] w_data_ccw [2];
    logic                  w_win_ccw  [2];
    logic                  w_send     [2];

    always_comb begin
        w_req_cw[0]   = bus.req_cw_even;
        w_req_cw[1]   = bus.req_cw_odd;
        w_req_ccw[0]  = bus.req_ccw_even;
        w_req_ccw[1]  = bus.req_ccw_odd;
        w_data_cw[0]  = bus.data_cw_even;
        w_data_cw[1]  = bus.data_cw_odd;
        w_data_ccw[0] = bus.data_ccw_even;
        w_data_ccw[1] = bus.data_ccw_odd;
        for (int unsigned v = 0; v < 2; v++) begin
            // ccw wins when it is alone or when contention favours it
            w_win_ccw[v] = w_req_ccw[v] && (!w_req_cw[v] || r_prio[v]);
            w_send[v]    = (r_state[v] == FULL) && bus.pero && (bus.polarity == (v == 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned v = 0; v < 2; v++) begin
                r_state[v]   <= IDLE;
                r_slot[v]    <= '0;
                r_prio[v]    <= 1'b0;
                r_gnt_cw[v]  <= 1'b0;
                r_gnt_ccw[v] <= 1'b0;
            end
            r_peso <= 1'b0;
            r_pedo <= '0;
        end else begin
            r_peso <= 1'b0;
            for (int unsigned v = 0; v < 2; v++) begin
                r_gnt_cw[v]  <= 1'b0;
                r_gnt_ccw[v] <= 1'b0;
                case (r_state[v])
                    IDLE: begin
                        if (w_req_cw[v] || w_req_ccw[v]) begin
                            r_slot[v]    <= w_win_ccw[v] ? w_data_ccw[v] : w_data_cw[v];
                            r_gnt_cw[v]  <= !w_win_ccw[v];
                            r_gnt_ccw[v] <= w_win_ccw[v];
                            r_prio[v]    <= !w_win_ccw[v];
                            r_state[v]   <= FULL;
                        end
                    end
                    FULL: begin
                        // Polarity is exclusive, so at most one engine writes pedo per edge
                        if (w_send[v]) begin
                            r_pedo     <= r_slot[v];
                            r_peso     <= 1'b1;
                            r_state[v] <= IDLE;
                        end
                    end
                    default: r_state[v] <= IDLE;
                endcase
            end
        end
    end

    assign bus.gnt_cw_even  = r_gnt_cw[0];
    assign bus.gnt_cw_odd   = r_gnt_cw[1];
    assign bus.gnt_ccw_even = r_gnt_ccw[0];
    assign bus.gnt_ccw_odd  = r_gnt_ccw[1];
    assign bus.peso         = r_peso;
    assign bus.pedo         = r_pedo;
endmodule

// File: tb/tb_eject_arbiter.sv
// Directed plus randomized bench for eject_arbiter against a per-VC slot/turn model.
module tb_eject_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    eject_arbiter_if #(.DATA_WIDTH(64)) bus ();
    eject_arbiter #(.DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: per VC, whether the slot holds a flit, its content, and whether cw won last
    bit          m_full    [2];
    logic [63:0] m_slot    [2];
    bit          m_last_cw [2];
    logic [63:0] m_pedo;
    bit          tog;
    int          gcount [2];
    logic [63:0] sends [$];

    localparam logic [63:0] D_A5   = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] D_CW_O = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_CC_O = 64'h5555_6666_7777_8888;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            m_full[v] = 0; m_slot[v] = '0; m_last_cw[v] = 0; gcount[v] = 0;
        end
        m_pedo = '0;
    endtask

    task automatic drive_idle();
        bus.req_cw_even = 0; bus.req_cw_odd = 0; bus.req_ccw_even = 0; bus.req_ccw_odd = 0;
        bus.data_cw_even = '0; bus.data_cw_odd = '0; bus.data_ccw_even = '0; bus.data_ccw_odd = '0;
    endtask

    // Mid-cycle async reset; returns at posedge+1 with rst released
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_peso", {63'b0, bus.peso}, 64'd0);
        chk("rst_pedo", bus.pedo, 64'd0);
        chk("rst_gnt", {60'b0, bus.gnt_cw_even, bus.gnt_ccw_even, bus.gnt_cw_odd, bus.gnt_ccw_odd}, 64'd0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Predict one edge from the currently driven inputs, advance, compare
    task automatic step();
        logic [3:0]  eg;
        logic        ep;
        logic        rc, rq, ccw_wins;
        logic [63:0] dc, dq;
        eg = '0;
        ep = 1'b0;
        for (int v = 0; v < 2; v++) begin
            rc = (v == 1) ? bus.req_cw_odd    : bus.req_cw_even;
            rq = (v == 1) ? bus.req_ccw_odd   : bus.req_ccw_even;
            dc = (v == 1) ? bus.data_cw_odd   : bus.data_cw_even;
            dq = (v == 1) ? bus.data_ccw_odd  : bus.data_ccw_even;
            if (!m_full[v]) begin
                if (rc || rq) begin
                    ccw_wins = rq && (!rc || m_last_cw[v]);
                    m_slot[v] = ccw_wins ? dq : dc;
                    m_full[v] = 1;
                    m_last_cw[v] = !ccw_wins;
                    if (ccw_wins) eg[(v == 1) ? 0 : 2] = 1'b1;
                    else          eg[(v == 1) ? 1 : 3] = 1'b1;
                end
            end else if (bus.pero && (bus.polarity == (v == 1))) begin
                ep = 1'b1;
                m_pedo = m_slot[v];
                m_full[v] = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("gnt", {60'b0, bus.gnt_cw_even, bus.gnt_ccw_even, bus.gnt_cw_odd, bus.gnt_ccw_odd}, {60'b0, eg});
        chk("peso", {63'b0, bus.peso}, {63'b0, ep});
        chk("pedo", bus.pedo, m_pedo);
        if (bus.gnt_cw_even || bus.gnt_ccw_even) gcount[0]++;
        if (bus.gnt_cw_odd || bus.gnt_ccw_odd) gcount[1]++;
        if (bus.peso) sends.push_back(bus.pedo);
        if (tog) bus.polarity = ~bus.polarity;
    endtask

    initial begin
        drive_idle();
        bus.pero = 1'b0;
        bus.polarity = 1'b0;
        tog = 0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset then contention: cw goes first
        do_reset();
        bus.req_cw_even = 1; bus.req_ccw_even = 1;
        bus.data_cw_even = 64'hC0; bus.data_ccw_even = 64'hCC;
        step();
        chk("first_gnt_cw_even", {63'b0, bus.gnt_cw_even}, 64'd1);
        drive_idle();
        bus.pero = 1; tog = 1;
        repeat (3) step();

        // Single flit latency and pedo hold
        do_reset();
        tog = 1; bus.pero = 1; bus.polarity = 1;
        bus.req_cw_even = 1; bus.data_cw_even = D_A5;
        step();
        chk("single_gnt", {63'b0, bus.gnt_cw_even}, 64'd1);
        drive_idle();
        step();
        chk("single_peso", {63'b0, bus.peso}, 64'd1);
        chk("single_pedo", bus.pedo, D_A5);
        repeat (3) step();
        chk("single_pedo_hold", bus.pedo, D_A5);

        // Round robin on odd VC
        do_reset();
        sends.delete();
        bus.pero = 1; tog = 1;
        bus.req_cw_odd = 1; bus.req_ccw_odd = 1;
        bus.data_cw_odd = D_CW_O; bus.data_ccw_odd = D_CC_O;
        repeat (16) step();
        drive_idle();
        chk("rr_count", {63'b0, sends.size() >= 4}, 64'd1);
        for (int i = 0; i < 4; i++)
            if (i < sends.size()) chk("rr_order", sends[i], (i % 2 == 0) ? D_CW_O : D_CC_O);

        // Backpressure
        do_reset();
        bus.pero = 0; tog = 1;
        bus.req_cw_even = 1; bus.req_ccw_odd = 1;
        bus.data_cw_even = 64'hE0E0; bus.data_ccw_odd = 64'h0D0D;
        step();
        repeat (10) step();
        chk("bp_gnt_even", gcount[0], 64'd1);
        chk("bp_gnt_odd", gcount[1], 64'd1);
        drive_idle();
        bus.pero = 1;
        repeat (3) step();

        // Concurrent VC grants
        do_reset();
        bus.pero = 1; tog = 1; bus.polarity = 0;
        bus.req_ccw_even = 1; bus.req_cw_odd = 1;
        bus.data_ccw_even = 64'hAAAA; bus.data_cw_odd = 64'hBBBB;
        step();
        chk("conc_gnt", {62'b0, bus.gnt_ccw_even, bus.gnt_cw_odd}, 64'd3);
        drive_idle();
        repeat (4) step();

        // Reset while a slot is full drops the flit
        do_reset();
        bus.pero = 0; tog = 1;
        bus.req_cw_even = 1; bus.data_cw_even = 64'hDEAD;
        step();
        drive_idle();
        step();
        do_reset();
        sends.delete();
        bus.pero = 1;
        repeat (4) step();
        chk("rst_drop", sends.size(), 64'd0);
        bus.req_ccw_even = 1; bus.data_ccw_even = 64'hBEEF;
        step();
        chk("rst_regrant", {63'b0, bus.gnt_ccw_even}, 64'd1);
        drive_idle();
        repeat (3) step();

        // Randomized traffic
        tog = 0;
        for (int n = 0; n < 400; n++) begin
            bus.req_cw_even  = $urandom_range(0, 1);
            bus.req_cw_odd   = $urandom_range(0, 1);
            bus.req_ccw_even = $urandom_range(0, 1);
            bus.req_ccw_odd  = $urandom_range(0, 1);
            bus.data_cw_even  = {$urandom, $urandom};
            bus.data_cw_odd   = {$urandom, $urandom};
            bus.data_ccw_even = {$urandom, $urandom};
            bus.data_ccw_odd  = {$urandom, $urandom};
            bus.pero     = ($urandom_range(0, 3) != 0);
            bus.polarity = $urandom_range(0, 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eject_arbiter.md
# eject_arbiter

Local-ejection scheduler for a ring router node. Shares the single PE-bound output link between the clockwise (cw) and counter-clockwise (ccw) input channels, independently per virtual channel (even/odd). Uses one output buffer slot and a round-robin arbiter per VC. A slot drains only in the link cycle whose polarity matches its VC.

## Interface
- DATA_WIDTH, 64, flit width in bits
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- polarity  input  1  link phase; 0 = even-VC cycle, 1 = odd-VC cycle
- req_cw_even, req_cw_odd, req_ccw_even, req_ccw_odd  input  1 each  requester holds a valid flit for that VC
- data_cw_even, data_cw_odd, data_ccw_even, data_ccw_odd  input  DATA_WIDTH each  flit from the requester's input buffer
- gnt_cw_even, gnt_cw_odd, gnt_ccw_even, gnt_ccw_odd  output  1 each  one-cycle pulse; the flit was captured
- pero  input  1  PE side ready to accept a flit
- peso  output  1  one-cycle send strobe toward the PE
- pedo  output  DATA_WIDTH  flit toward the PE; valid when peso=1

## Operation
- Two identical, independent VC engines, v ∈ {even, odd}. Each engine holds:
  - a DATA_WIDTH slot register
  - state: IDLE (slot empty) or FULL (slot holds a flit)
  - prio_v: 0 = cw preferred, 1 = ccw preferred
- Target polarity: even engine = 0, odd engine = 1.
- IDLE, no request for v: stay IDLE, no grant.
- IDLE, exactly one of req_cw_v / req_ccw_v high: that requester wins.
- IDLE, both high: the winner is cw if prio_v=0, ccw if prio_v=1.
- On a win, at the same edge:
  - slot <= winner's data_*_v, unmodified (no hop-field change on ejection)
  - gnt_<winner>_v <= 1
  - state <= FULL
  - prio_v <= 1 if the winner was cw, 0 if the winner was ccw. prio_v updates on every grant, contended or not.
- FULL: no grants for v. Requests are ignored (not queued).
- FULL, pero=1 and polarity equals the target polarity, at the edge:
  - pedo <= slot
  - peso <= 1
  - state <= IDLE
- FULL, otherwise: hold the slot indefinitely.
- Only one engine can send in a given cycle because polarity is exclusive. peso=1 means the flit came from the engine matching the polarity sampled at that edge.
- Grant outputs are registered pulses of exactly one cycle. They return to 0 at the next edge.
- pedo holds its last value whenever peso=0. peso is 0 in every cycle with no send.
- Requester obligation: after seeing its gnt, deassert the request or present the next flit. A request still high in the grant cycle is ignored, because the engine is FULL.

## Timing
- Reset (async assert, any time), outputs:
  - peso=0, pedo=0
  - all four gnt_*=0
- Reset, internal state:
  - both engines IDLE, slots=0
  - prio_even=prio_odd=0 (cw first)
- A flit held in a slot during reset is dropped. The first edge after deassertion behaves as IDLE.
- Request to grant: a request sampled high at edge N (engine IDLE) gives gnt high during cycle N..N+1. Data is captured at edge N.
- Capture to send: the earliest edge is N+1, if pero=1 and polarity matches there. Otherwise the first later edge meeting both conditions.
- Send to next grant: the engine is IDLE after the send edge. The earliest next capture is the following edge (≥1 cycle gap).
- With polarity toggling every cycle and pero=1, each VC sustains one flit per 2 cycles for a single requester. With two contending requesters it alternates winners strictly (cw, ccw, cw, …).
- Simultaneous events:
  - Even and odd engines may grant in the same cycle.
  - A send and a grant never occur on the same engine at the same edge.
- pero=0: no sends. Slots stay FULL. Both engines stop granting once full.

## Test plan
- Reset: assert rst mid-cycle -> peso=0, pedo=0, all gnt_*=0 immediately. Then hold req_cw_even=1 and req_ccw_even=1 -> first grant is gnt_cw_even.
- Single flit: pero=1, polarity toggling starting at 1, req_cw_even=1 with data_cw_even=64'hA5A5_0000_0000_0001 at edge N:
  - gnt_cw_even is high for cycle N only
  - peso=1 with pedo=64'hA5A5_0000_0000_0001 after edge N+1 (polarity=0 there)
  - pedo is unchanged after that
- Round robin: req_cw_odd and req_ccw_odd held high with distinct data, pero=1 -> odd grants alternate cw, ccw, cw, ccw. Four consecutive odd-phase sends output the data in that order.
- Backpressure: pero=0, both engines receive one flit each -> exactly one gnt per VC, peso stays 0 for 10 cycles. Raise pero -> the even flit leaves on the first polarity=0 edge and the odd flit on the first polarity=1 edge.
- Concurrent VCs: req_ccw_even and req_cw_odd asserted at the same edge -> gnt_ccw_even and gnt_cw_odd pulse in the same cycle. The sends occur on consecutive edges in polarity order.
- Reset mid-FULL: capture an even flit with pero=0, assert rst, release, then set pero=1 -> no peso for that flit. A new request is granted normally.
